// File: rtl/mma_pkt_pkg.sv
// Shared definitions for the MMA packet framer and the matching RX deframer.
// Build option: MMA_PKT_CRC8_EN selects CRC-8 for the trailing check byte.
// When MMA_PKT_CRC8_EN is not defined, the check byte is the two's-complement sum.
package mma_pkt_pkg;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;
  localparam logic [7:0] CRC8_POLY   = 8'h07;

  typedef enum logic [2:0] {
    StIdle,
    StSof,
    StLen,
    StLoad,
    StData,
    StCsum,
    StDone
  } tx_state_e;

  typedef enum logic [1:0] {
    HsIdle,
    HsIssue,
    HsDrain
  } hs_phase_e;

  // CRC-8, MSB first, no reflection, no final XOR.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  // Fold one byte into the running check value.
  function automatic logic [7:0] check_update(input logic [7:0] acc, input logic [7:0] data);
`ifdef MMA_PKT_CRC8_EN
    return crc8_update(acc, data);
`else
    return acc + data;
`endif
  endfunction

  // Byte actually placed on the wire for the running check value.
  function automatic logic [7:0] check_final(input logic [7:0] acc);
`ifdef MMA_PKT_CRC8_EN
    return acc;
`else
    return 8'h00 - acc;
`endif
  endfunction

endpackage

// File: rtl/mma_tx_byte_hs.sv
// One-byte UART transmit handshake: ISSUE holds tx_begin until busy is seen,
// DRAIN waits for busy to fall. A timeout aborts ISSUE if busy never rises.
module mma_tx_byte_hs
  import mma_pkt_pkg::*;
#(
  parameter int unsigned HS_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       send,
  input  logic [7:0] tx_byte,
  input  logic       uart_tx_busy,
  output logic [7:0] uart_tx_data,
  output logic       uart_tx_begin,
  output logic       byte_done,
  output logic       timeout
);

  localparam int unsigned CntW = $clog2(HS_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(HS_TIMEOUT - 1);

  hs_phase_e       phase_q, phase_d;
  logic [7:0]      data_q, data_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Phase register, held byte and ISSUE cycle counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= HsIdle;
      data_q  <= 8'h00;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next phase; byte_done and timeout are same-cycle strobes to the sequencer.
  always_comb begin
    phase_d   = phase_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    byte_done = 1'b0;
    timeout   = 1'b0;
    case (phase_q)
      HsIdle: begin
        if (send) begin
          phase_d = HsIssue;
          data_d  = tx_byte;
          cnt_d   = '0;
        end
      end
      HsIssue: begin
        if (uart_tx_busy) begin
          phase_d = HsDrain;
        end else if (cnt_q == CntLast) begin
          timeout = 1'b1;
          phase_d = HsIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      HsDrain: begin
        if (!uart_tx_busy) begin
          byte_done = 1'b1;
          phase_d   = HsIdle;
        end
      end
      default: phase_d = HsIdle;
    endcase
  end

  // Data stays on the bus from ISSUE until the next byte is loaded.
  assign uart_tx_data  = data_q;
  assign uart_tx_begin = (phase_q == HsIssue);

endmodule

// File: rtl/mma_packet_tx.sv
// Packet framer: [SOF][LEN][payload MSB first][CSUM] over the UART byte port.
// Build option: MMA_PKT_CRC8_EN turns the CSUM byte into CRC-8 (see mma_pkt_pkg).
module mma_packet_tx
  import mma_pkt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter logic [7:0]  SOF_BYTE   = SOF_DEFAULT,
  parameter int unsigned HS_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pkt_start,
  input  logic [7:0]            pkt_len,
  input  logic [DATA_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic [7:0]            uart_tx_data,
  output logic                  uart_tx_begin,
  input  logic                  uart_tx_busy,
  output logic                  busy,
  output logic                  done,
  output logic                  hs_error
);

  localparam int unsigned BPW = DATA_WIDTH / 8;
  localparam int unsigned BcW = (BPW > 1) ? $clog2(BPW) : 1;

  tx_state_e             state_q, state_d;
  logic [7:0]            word_cnt_q, word_cnt_d;
  logic [BcW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [7:0]            csum_q, csum_d;
  logic                  sent_q, sent_d;
  logic                  hs_error_q, hs_error_d;

  logic       send;
  logic [7:0] tx_byte;
  logic       byte_done;
  logic       hs_timeout;

  mma_tx_byte_hs #(
    .HS_TIMEOUT (HS_TIMEOUT)
  ) u_byte_hs (
    .clk           (clk),
    .reset_n       (reset_n),
    .send          (send),
    .tx_byte       (tx_byte),
    .uart_tx_busy  (uart_tx_busy),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_begin (uart_tx_begin),
    .byte_done     (byte_done),
    .timeout       (hs_timeout)
  );

  // Sequencer state, counters, payload shifter and running check value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      word_cnt_q <= 8'h00;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      csum_q     <= 8'h00;
      sent_q     <= 1'b0;
      hs_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      csum_q     <= csum_d;
      sent_q     <= sent_d;
      hs_error_q <= hs_error_d;
    end
  end

  // Byte sequencing: each byte state issues one send, then waits for done or timeout.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    csum_d     = csum_q;
    sent_d     = sent_q;
    hs_error_d = 1'b0;
    send       = 1'b0;
    word_ready = 1'b0;

    case (state_q)
      StSof:   tx_byte = SOF_BYTE;
      StLen:   tx_byte = word_cnt_q;
      StData:  tx_byte = shift_q[DATA_WIDTH-1 -: 8];
      StCsum:  tx_byte = check_final(csum_q);
      default: tx_byte = 8'h00;
    endcase

    case (state_q)
      StIdle: begin
        if (pkt_start) begin
          word_cnt_d = pkt_len;
          byte_cnt_d = '0;
          csum_d     = 8'h00;
          sent_d     = 1'b0;
          state_d    = StSof;
        end
      end
      StLoad: begin
        word_ready = 1'b1;
        if (word_valid) begin
          shift_d = word_data;
          state_d = StData;
        end
      end
      StSof, StLen, StData, StCsum: begin
        if (!sent_q) begin
          send   = 1'b1;
          sent_d = 1'b1;
          // SOF and the check byte itself are excluded from the check value.
          if (state_q == StLen || state_q == StData) begin
            csum_d = check_update(csum_q, tx_byte);
          end
        end else if (hs_timeout) begin
          sent_d     = 1'b0;
          hs_error_d = 1'b1;
          state_d    = StIdle;
        end else if (byte_done) begin
          sent_d = 1'b0;
          case (state_q)
            StSof: state_d = StLen;
            StLen: state_d = (word_cnt_q == 8'h00) ? StCsum : StLoad;
            StData: begin
              shift_d = shift_q << 8;
              if (byte_cnt_q == BcW'(BPW - 1)) begin
                byte_cnt_d = '0;
                word_cnt_d = word_cnt_q - 8'd1;
                state_d    = (word_cnt_q == 8'd1) ? StCsum : StLoad;
              end else begin
                byte_cnt_d = byte_cnt_q + BcW'(1);
              end
            end
            default: state_d = StDone;
          endcase
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign hs_error = hs_error_q;

endmodule

// File: tb/tb_mma_packet_tx.sv
// Bench for mma_packet_tx with a behavioural UART and a byte scoreboard.
// Build option: MMA_PKT_CRC8_EN switches the reference check byte to CRC-8.
`timescale 1ns/1ps
module tb_mma_packet_tx;

  localparam int unsigned DW = 16;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          pkt_start = 1'b0;
  logic [7:0]    pkt_len = 8'h00;
  logic [DW-1:0] word_data = '0;
  logic          word_valid = 1'b0;
  logic          word_ready;
  logic [7:0]    uart_tx_data;
  logic          uart_tx_begin;
  logic          uart_tx_busy;
  logic          busy, done, hs_error;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  bit model_en = 1'b1;
  int proto_viol = 0;

  always #5 clk = ~clk;

  mma_packet_tx #(
    .DATA_WIDTH (DW),
    .SOF_BYTE   (8'hA5),
    .HS_TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pkt_start     (pkt_start),
    .pkt_len       (pkt_len),
    .word_data     (word_data),
    .word_valid    (word_valid),
    .word_ready    (word_ready),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_begin (uart_tx_begin),
    .uart_tx_busy  (uart_tx_busy),
    .busy          (busy),
    .done          (done),
    .hs_error      (hs_error)
  );

  // UART model: busy rises 2 cycles after begin, stays high 20 cycles.
  typedef enum int {MIdle, MWait, MBusy} m_state_e;
  m_state_e   m_st;
  int         m_cnt;
  logic [7:0] m_byte;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_st         <= MIdle;
      m_cnt        <= 0;
      m_byte       <= 8'h00;
      uart_tx_busy <= 1'b0;
    end else begin
      case (m_st)
        MIdle: if (model_en && uart_tx_begin) m_st <= MWait;
        MWait: begin
          uart_tx_busy <= 1'b1;
          m_byte       <= uart_tx_data;
          m_cnt        <= 0;
          m_st         <= MBusy;
        end
        default: begin
          if (uart_tx_data !== m_byte) proto_viol = proto_viol + 1;
          if (m_cnt == 19) begin
            if (uart_tx_begin) proto_viol = proto_viol + 1;
            uart_tx_busy <= 1'b0;
            rx_q.push_back(m_byte);
            m_st <= MIdle;
          end else begin
            m_cnt <= m_cnt + 1;
          end
        end
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference frame: SOF, LEN, payload MSB first, then check byte.
  task automatic push_frame(input int len, input logic [DW-1:0] w0, input logic [DW-1:0] w1);
    logic [7:0]    pl[$];
    logic [7:0]    acc;
    logic [DW-1:0] w;
    pl.push_back(8'(len));
    for (int i = 0; i < len; i++) begin
      w = (i == 0) ? w0 : w1;
      for (int b = DW / 8 - 1; b >= 0; b--) pl.push_back(w[b*8 +: 8]);
    end
    exp_q.push_back(8'hA5);
    acc = 8'h00;
    foreach (pl[i]) begin
      exp_q.push_back(pl[i]);
`ifdef MMA_PKT_CRC8_EN
      acc = acc ^ pl[i];
      for (int k = 0; k < 8; k++) acc = acc[7] ? ({acc[6:0], 1'b0} ^ 8'h07) : {acc[6:0], 1'b0};
`else
      acc = acc + pl[i];
`endif
    end
`ifdef MMA_PKT_CRC8_EN
    exp_q.push_back(acc);
`else
    exp_q.push_back(8'h00 - acc);
`endif
  endtask

  // Start a packet and feed words until done/hs_error, or until abort_rx bytes are
  // received and the next byte is being issued.
  task automatic run_packet(input int len, input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                            input int stall, input int abort_rx,
                            output int n_done, output int n_err, output int n_ready,
                            output int n_stall_bad, output bit finished);
    int idx = 0;
    bit pend = 1'b0;
    int stall_left = -1;
    n_done = 0; n_err = 0; n_ready = 0; n_stall_bad = 0; finished = 1'b0;
    @(negedge clk);
    pkt_start = 1'b1;
    pkt_len   = 8'(len);
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      @(negedge clk);
      pkt_start = 1'b0;
      if (pend) begin idx++; pend = 1'b0; end
      if (done) n_done++;
      if (hs_error) n_err++;
      if (word_ready) n_ready++;
      if (word_ready && stall_left < 0) stall_left = stall;
      if (stall_left > 0) begin
        stall_left--;
        if (uart_tx_begin || hs_error) n_stall_bad++;
      end
      word_data  = (idx == 0) ? w0 : w1;
      word_valid = (idx < len) && (stall_left == 0);
      if (word_ready && word_valid) pend = 1'b1;
      if (done || hs_error) finished = 1'b1;
      if (abort_rx > 0 && rx_q.size() >= abort_rx && uart_tx_begin) finished = 1'b1;
    end
    word_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (uart_tx_begin !== 1'b0) begin errors++; $display("FAIL reset_begin: got %b expected 0", uart_tx_begin); end
    checks++; if (uart_tx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", uart_tx_data); end
    checks++; if (word_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", word_ready); end
    checks++; if ({done, hs_error} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b expected 00", {done, hs_error}); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_two_words();
    int nd, ne, nr, ns, pv; bit fin; logic [7:0] e, r;
    pv = proto_viol;
    push_frame(2, 16'h1234, 16'hABCD);
    run_packet(2, 16'h1234, 16'hABCD, 0, 0, nd, ne, nr, ns, fin);
    checks++; if (nd !== 1) begin errors++; $display("FAIL two_words_done: got %0d pulses expected 1", nd); end
    checks++; if (ne !== 0) begin errors++; $display("FAIL two_words_hs_error: got %0d expected 0", ne); end
    checks++; if (proto_viol !== pv) begin errors++; $display("FAIL two_words_protocol: got %0d violations expected 0", proto_viol - pv); end
    checks++; if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL two_words_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      checks++; if (r !== e) begin errors++; $display("FAIL two_words_byte: got %h expected %h", r, e); end
    end
    exp_q.delete(); rx_q.delete();
  endtask

  task automatic test_zero_len();
    int nd, ne, nr, ns; bit fin; logic [7:0] e, r;
    push_frame(0, '0, '0);
    run_packet(0, '0, '0, 0, 0, nd, ne, nr, ns, fin);
    checks++; if (nd !== 1) begin errors++; $display("FAIL zero_len_done: got %0d pulses expected 1", nd); end
    checks++; if (nr !== 0) begin errors++; $display("FAIL zero_len_ready: got %0d ready cycles expected 0", nr); end
    checks++; if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL zero_len_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      checks++; if (r !== e) begin errors++; $display("FAIL zero_len_byte: got %h expected %h", r, e); end
    end
    exp_q.delete(); rx_q.delete();
  endtask

  task automatic test_stall();
    int nd, ne, nr, ns; bit fin; logic [7:0] e, r;
    push_frame(1, 16'h5AC3, '0);
    run_packet(1, 16'h5AC3, '0, 500, 0, nd, ne, nr, ns, fin);
    checks++; if (ns !== 0) begin errors++; $display("FAIL stall_quiet: got %0d active cycles expected 0", ns); end
    checks++; if (nr < 500) begin errors++; $display("FAIL stall_ready_held: got %0d ready cycles expected >= 500", nr); end
    checks++; if (nd !== 1 || ne !== 0) begin errors++; $display("FAIL stall_outcome: got done=%0d err=%0d expected 1/0", nd, ne); end
    checks++; if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL stall_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      checks++; if (r !== e) begin errors++; $display("FAIL stall_byte: got %h expected %h", r, e); end
    end
    exp_q.delete(); rx_q.delete();
  endtask

  task automatic test_timeout();
    int begin_cycles = 0; int n_err = 0; bit seen = 1'b0;
    logic begin_at_err = 1'b1; logic busy_at_err = 1'b1;
    model_en = 1'b0;
    @(negedge clk);
    pkt_start = 1'b1; pkt_len = 8'd1;
    for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
      @(negedge clk);
      pkt_start = 1'b0;
      if (uart_tx_begin) begin_cycles++;
      if (hs_error) begin
        n_err++; seen = 1'b1;
        begin_at_err = uart_tx_begin; busy_at_err = busy;
      end
    end
    checks++; if (n_err !== 1) begin errors++; $display("FAIL timeout_seen: got %0d pulses expected 1", n_err); end
    checks++; if (begin_cycles !== TO) begin errors++; $display("FAIL timeout_issue_cycles: got %0d expected %0d", begin_cycles, TO); end
    checks++; if (begin_at_err !== 1'b0 || busy_at_err !== 1'b0) begin errors++; $display("FAIL timeout_idle: got begin=%b busy=%b expected 0/0", begin_at_err, busy_at_err); end
    @(negedge clk);
    checks++; if (hs_error !== 1'b0) begin errors++; $display("FAIL timeout_pulse_width: got %b expected 0", hs_error); end
    checks++; if (rx_q.size() !== 0) begin errors++; $display("FAIL timeout_no_bytes: got %0d expected 0", rx_q.size()); end
    rx_q.delete();
    model_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int nd, ne, nr, ns; bit fin; logic [7:0] e, r;
    run_packet(2, 16'h1234, 16'hABCD, 0, 4, nd, ne, nr, ns, fin);
    checks++; if (fin !== 1'b1 || nd !== 0) begin errors++; $display("FAIL mid_reach_third: got fin=%b done=%0d expected 1/0", fin, nd); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({busy, uart_tx_begin, word_ready, done, hs_error} !== 5'b0) begin
      errors++; $display("FAIL mid_reset_outputs: got %b expected 00000", {busy, uart_tx_begin, word_ready, done, hs_error});
    end
    checks++; if (uart_tx_data !== 8'h00) begin errors++; $display("FAIL mid_reset_data: got %h expected 00", uart_tx_data); end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete(); rx_q.delete();
    push_frame(1, 16'h0001, '0);
    run_packet(1, 16'h0001, '0, 0, 0, nd, ne, nr, ns, fin);
    checks++; if (nd !== 1) begin errors++; $display("FAIL mid_new_done: got %0d expected 1", nd); end
    checks++; if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL mid_new_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      checks++; if (r !== e) begin errors++; $display("FAIL mid_new_byte: got %h expected %h", r, e); end
    end
    exp_q.delete(); rx_q.delete();
  endtask

  task automatic test_check_byte();
    int nd, ne, nr, ns; bit fin; logic [7:0] e, r, last;
    logic [7:0] known;
`ifdef MMA_PKT_CRC8_EN
    known = 8'h6B;
`else
    known = 8'hFF;
`endif
    last = 8'hxx;
    push_frame(1, 16'h0000, '0);
    run_packet(1, 16'h0000, '0, 0, 0, nd, ne, nr, ns, fin);
    checks++; if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL check_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front(); last = r;
      checks++; if (r !== e) begin errors++; $display("FAIL check_byte: got %h expected %h", r, e); end
    end
    checks++; if (last !== known) begin errors++; $display("FAIL check_known_value: got %h expected %h", last, known); end
    exp_q.delete(); rx_q.delete();
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_zero_len();
    test_stall();
    test_timeout();
    test_reset_mid();
    test_check_byte();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
